reservation_station: RTL
========================

# reservation_station

Operand-waiting buffer between the reorder buffer's dispatch outputs and the ALU. It accepts one renamed instruction per cycle, tagged with its ROB index. It captures missing operands from the ALU and memory result broadcasts, then issues one operand-complete instruction per cycle to the ALU. Issue order is lowest-index by default, or oldest-first when compiled with the age option.

## Interface
Parameters:
- DEPTH, 4, number of entries (2..8)
- AGE_W, 4, saturating age counter width per entry (used only with RS_AGE_EN)

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  reset, asynchronous, active-high
- flush  input  1  synchronous clear of all entries (mispredict)
- op_in  input  5  dispatched opcode; 5'b11111 = no dispatch
- value1_in, value2_in  input  32  operand values
- query1_in, query2_in  input  3  ROB tag producing the operand; 0 = value valid
- imm_in  input  32  immediate
- target_in  input  3  destination ROB index (1..7)
- alu_num  input  3  ALU broadcast tag; 0 = none
- alu_value  input  32  ALU broadcast value
- mem_num  input  3  memory broadcast tag; 0 = none
- mem_value  input  32  memory broadcast value
- rs_full  output  1  registered; upstream must not dispatch while high
- issue_op  output  5  opcode to ALU; 5'b11111 = idle
- issue_a, issue_b, issue_imm  output  32  operands and immediate
- issue_target  output  3  ROB index of the issued instruction; 0 when idle
- overflow  output  1  sticky error: a dispatch arrived with no free entry

## Operation
- Each entry holds: busy, op, v1, q1, v2, q2, imm, target, and age (when RS_AGE_EN).
- Allocate: if op_in != 5'b11111 and a free entry exists, write it into the lowest-index free entry.
  - If no free entry exists, drop the dispatch and set overflow. Only rst clears overflow.
- Dispatch bypass: if query1_in or query2_in equals a nonzero alu_num or mem_num in the same cycle, store the broadcast value and a q of 0.
  - This applies to each operand and each broadcast independently.
- Wakeup: for each busy entry whose q1 or q2 equals a nonzero alu_num or mem_num, load the value and clear the q.
  - If alu_num and mem_num carry the same tag, alu_value wins.
- Ready: an entry is ready when busy, q1==0 and q2==0.
- Select: at most one ready entry issues per cycle. The default is the lowest index.
- Issue: drive the issue_* registers from the selected entry and clear its busy bit at the same edge.
  - With no ready entry, issue_op is 5'b11111 and issue_target is 0. The other issue outputs hold their values.
- Entry reuse: an entry freed by issue can be reallocated in the same cycle.
- rs_full: registered; set to 1 when the busy count after this edge's updates is >= DEPTH-1.
  - The one-slot margin covers the one-cycle lag before the ROB sees the flag.
- flush: clear all busy bits, force issue_op to 5'b11111 and issue_target to 0, and set rs_full to 0.
  - A dispatch arriving in the same cycle as flush is discarded. overflow is kept.
- Reset values: all busy 0, rs_full 0, overflow 0, issue_op 5'b11111, issue_target 0, issue_a/b/imm 0, ages 0.

## Timing
- Dispatch to earliest issue: 1 cycle. An entry written at edge N with q1=q2=0 appears on issue_* after edge N+1.
- It never issues at the same edge it is written.
- Wakeup at edge N makes the entry eligible for selection at edge N+1.
- With bypass at dispatch, the entry's eligibility is the same as for dispatch with q=0.
- Wakeup, allocation, issue and rs_full are all computed from pre-edge state and written together at one edge.
- Asserting rst mid-operation clears state immediately, with no clock required.

## Configuration
- RS_AGE_EN defined:
  - Each busy entry's age increments every cycle, saturating at 2^AGE_W-1, and resets to 0 on allocation.
  - Select the ready entry with the largest age; ties go to the lowest index.
- RS_AGE_EN undefined:
  - No age state is built. Select the lowest-index ready entry.

## Test plan
- Reset: assert rst asynchronously mid-clock -> issue_op=5'b11111, issue_target=0, rs_full=0, overflow=0 immediately.
- Direct issue: dispatch ADD (00000), v1=5, v2=7, q1=q2=0, target=3 -> next cycle issue_op=00000, issue_a=5, issue_b=7, issue_target=3; the following cycle is idle.
- Wakeup: dispatch SUB with q1=2, target=4; two cycles later alu_num=2, alu_value=0x10 -> issue_a=0x10, issue_target=4 one cycle after the broadcast.
- Bypass: dispatch with q2=5 while mem_num=5, mem_value=0xABCD -> issues the next cycle with issue_b=0xABCD.
- Full/overflow (DEPTH=4): dispatch 3 blocked entries -> rs_full=1. A 4th is accepted; a 5th sets overflow=1 and the entry count stays 4. Then flush -> rs_full=0 and there is no issue the next cycle.
- Order (RS_AGE_EN): fill entry 2 first, entry 0 later, wake both in the same cycle -> entry 2 issues first. Without the macro, entry 0 issues first.

Source files
------------

// File: rtl/reservation_station.sv
// reservation_station: operand-waiting buffer between ROB dispatch and the ALU.
// Build option RS_AGE_EN: oldest-ready-first select with per-entry saturating ages; otherwise lowest ready index wins.

module rs_entry (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        alloc,
  input  logic        clr,
  input  logic [4:0]  op_n,
  input  logic [31:0] v1_n,
  input  logic [2:0]  q1_n,
  input  logic [31:0] v2_n,
  input  logic [2:0]  q2_n,
  input  logic [31:0] imm_n,
  input  logic [2:0]  target_n,
  input  logic [2:0]  alu_num,
  input  logic [31:0] alu_value,
  input  logic [2:0]  mem_num,
  input  logic [31:0] mem_value,
  output logic        busy,
  output logic        busy_nxt,
  output logic        ready,
  output logic [4:0]  op,
  output logic [31:0] v1,
  output logic [31:0] v2,
  output logic [31:0] imm,
  output logic [2:0]  target
);
  logic [2:0] q1, q2;

  // Allocation beats issue so an entry freed this edge can be refilled at once.
  assign busy_nxt = !flush && (alloc || (busy && !clr));
  assign ready    = busy && q1 == 3'd0 && q2 == 3'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      op     <= 5'h1f;
      v1     <= '0;
      q1     <= '0;
      v2     <= '0;
      q2     <= '0;
      imm    <= '0;
      target <= '0;
    end else begin
      busy <= busy_nxt;
      if (alloc) begin
        op     <= op_n;
        v1     <= v1_n;
        q1     <= q1_n;
        v2     <= v2_n;
        q2     <= q2_n;
        imm    <= imm_n;
        target <= target_n;
      end else if (busy) begin
        if (q1 != 3'd0 && q1 == alu_num) begin
          v1 <= alu_value;
          q1 <= 3'd0;
        end else if (q1 != 3'd0 && q1 == mem_num) begin
          v1 <= mem_value;
          q1 <= 3'd0;
        end
        if (q2 != 3'd0 && q2 == alu_num) begin
          v2 <= alu_value;
          q2 <= 3'd0;
        end else if (q2 != 3'd0 && q2 == mem_num) begin
          v2 <= mem_value;
          q2 <= 3'd0;
        end
      end
    end
  end
endmodule

module reservation_station #(
  parameter int DEPTH = 4,
  parameter int AGE_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [4:0]  op_in,
  input  logic [31:0] value1_in,
  input  logic [31:0] value2_in,
  input  logic [2:0]  query1_in,
  input  logic [2:0]  query2_in,
  input  logic [31:0] imm_in,
  input  logic [2:0]  target_in,
  input  logic [2:0]  alu_num,
  input  logic [31:0] alu_value,
  input  logic [2:0]  mem_num,
  input  logic [31:0] mem_value,
  output logic        rs_full,
  output logic [4:0]  issue_op,
  output logic [31:0] issue_a,
  output logic [31:0] issue_b,
  output logic [31:0] issue_imm,
  output logic [2:0]  issue_target,
  output logic        overflow
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [3:0] FULL_AT = 4'(DEPTH - 1);

  logic [DEPTH-1:0]        busy, busy_nxt, ready, sel_oh, alloc_oh, free;
  logic [DEPTH-1:0][4:0]   ent_op;
  logic [DEPTH-1:0][31:0]  ent_v1, ent_v2, ent_imm;
  logic [DEPTH-1:0][2:0]   ent_target;
  logic [IW-1:0]           sel_idx;
  logic                    found, have_free, do_disp;
  logic [3:0]              cnt;
  logic [2:0]              bq1, bq2;
  logic [31:0]             bv1, bv2;

  // A broadcast in the dispatch cycle would otherwise be missed by the new entry.
  function automatic logic [34:0] capture(input logic [2:0] q, input logic [31:0] v,
                                          input logic [2:0] an, input logic [31:0] av,
                                          input logic [2:0] mn, input logic [31:0] mv);
    if (q != 3'd0 && q == an) return {3'd0, av};
    if (q != 3'd0 && q == mn) return {3'd0, mv};
    return {q, v};
  endfunction

  assign {bq1, bv1} = capture(query1_in, value1_in, alu_num, alu_value, mem_num, mem_value);
  assign {bq2, bv2} = capture(query2_in, value2_in, alu_num, alu_value, mem_num, mem_value);
  assign do_disp = op_in != 5'h1f && !flush;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    rs_entry u_ent (
      .clk(clk), .rst(rst), .flush(flush), .alloc(alloc_oh[i]), .clr(sel_oh[i]),
      .op_n(op_in), .v1_n(bv1), .q1_n(bq1), .v2_n(bv2), .q2_n(bq2),
      .imm_n(imm_in), .target_n(target_in),
      .alu_num(alu_num), .alu_value(alu_value), .mem_num(mem_num), .mem_value(mem_value),
      .busy(busy[i]), .busy_nxt(busy_nxt[i]), .ready(ready[i]),
      .op(ent_op[i]), .v1(ent_v1[i]), .v2(ent_v2[i]), .imm(ent_imm[i]), .target(ent_target[i])
    );
  end

`ifdef RS_AGE_EN
  logic [DEPTH-1:0][AGE_W-1:0] age;
  logic [AGE_W-1:0]            best;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_oh[i])                 age[i] <= '0;
        else if (busy[i] && age[i] != '1) age[i] <= age[i] + 1'b1;
      end
    end
  end

  // Strict '>' keeps ties on the lowest index.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    sel_oh  = '0;
    best    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && (!found || age[i] > best)) begin
        found   = 1'b1;
        sel_idx = i[IW-1:0];
        sel_oh  = '0;
        sel_oh[i] = 1'b1;
        best    = age[i];
      end
    end
  end
`else
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    sel_oh  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && !found) begin
        found     = 1'b1;
        sel_idx   = i[IW-1:0];
        sel_oh[i] = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    free      = ~busy | sel_oh;
    alloc_oh  = '0;
    have_free = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (free[i] && !have_free) begin
        have_free   = 1'b1;
        alloc_oh[i] = do_disp;
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + {3'd0, busy_nxt[i]};
  end

  // Full asserts one slot early to cover the ROB's one-cycle view lag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_full      <= 1'b0;
      overflow     <= 1'b0;
      issue_op     <= 5'h1f;
      issue_target <= '0;
      issue_a      <= '0;
      issue_b      <= '0;
      issue_imm    <= '0;
    end else begin
      rs_full <= cnt >= FULL_AT;
      if (do_disp && !have_free) overflow <= 1'b1;
      if (found && !flush) begin
        issue_op     <= ent_op[sel_idx];
        issue_a      <= ent_v1[sel_idx];
        issue_b      <= ent_v2[sel_idx];
        issue_imm    <= ent_imm[sel_idx];
        issue_target <= ent_target[sel_idx];
      end else begin
        issue_op     <= 5'h1f;
        issue_target <= '0;
      end
    end
  end
endmodule
